// File: rtl/nn_pkg.sv
// Shared neural-network types and constants.
// Used by the argmax stage and its neighbours.
package nn_pkg;

  localparam int NN_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } argmax_state_e;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_RELU,
    ACT_SIGMOID,
    ACT_TANH
  } activation_type_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/argmax_unit.sv
// Sequential argmax over a captured signed score vector.
// One comparator walks the vector one element per cycle.
module argmax_unit
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = NN_DATA_WIDTH,
  parameter int NUM_INPUTS = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic inputs_ready,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] inputs,
  input  logic result_ready,
  output logic [clog2_min1(NUM_INPUTS)-1:0] index,
  output logic signed [DATA_WIDTH-1:0] max_value,
  output logic result_valid,
  output logic busy
);

  localparam int IW = clog2_min1(NUM_INPUTS);
  localparam int DEPTH = 2 ** IW;
  localparam logic [IW-1:0] LAST = IW'(NUM_INPUTS - 1);

  argmax_state_e state_q, state_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] captured_q, captured_d;
  logic signed [DATA_WIDTH-1:0] best_value_q, best_value_d;
  logic [IW-1:0] best_index_q, best_index_d;
  logic [IW-1:0] count_q, count_d;
  logic load;

  always_comb begin
    state_d      = state_q;
    captured_d   = captured_q;
    best_value_d = best_value_q;
    best_index_d = best_index_q;
    count_d      = count_q;
    load         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        load = inputs_ready;
      end
      ST_SCAN: begin
        // strict compare keeps the lowest index on ties
        if ($signed(captured_q[count_q]) > best_value_q) begin
          best_value_d = $signed(captured_q[count_q]);
          best_index_d = count_q;
        end
        if (count_q == LAST) state_d = ST_DONE;
        else count_d = count_q + IW'(1);
      end
      ST_DONE: begin
        if (result_ready) begin
          load    = inputs_ready;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      captured_d = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        captured_d[i] = inputs[i];
      end
      best_value_d = $signed(inputs[0]);
      best_index_d = '0;
      count_d      = IW'(1);
      state_d      = (NUM_INPUTS == 1) ? ST_DONE : ST_SCAN;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      best_value_q <= '0;
      best_index_q <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      best_value_q <= best_value_d;
      best_index_q <= best_index_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    captured_q <= captured_d;
  end

  assign index        = best_index_q;
  assign max_value    = best_value_q;
  assign result_valid = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);

endmodule
